tmds_period_encoder: RTL

TMDS_PERIOD_ENCODER -- requirements
Module: tmds_period_encoder

---
 rtl/tmds_pkg.sv | 40 ++++
 rtl/tmds_chan_enc.sv | 66 ++++++
 rtl/tmds_period_encoder.sv | 99 +++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: shared constants and types for the TMDS period encoder.
//   Control codes for each CD value, guard-band codes per channel,
//   preamble CTL values, default look-ahead depth, channel mode enum,
//   and small helpers (control-code lookup, 8-bit popcount).
package tmds_pkg;

  localparam int LEAD_DFLT = 10;
  localparam int NUM_CH    = 3;

  localparam logic [9:0] CTL_CODE_00 = 10'h354;
  localparam logic [9:0] CTL_CODE_01 = 10'h0AB;
  localparam logic [9:0] CTL_CODE_10 = 10'h154;
  localparam logic [9:0] CTL_CODE_11 = 10'h2AB;

  localparam logic [9:0] GB_CH0 = 10'h2CC;
  localparam logic [9:0] GB_CH1 = 10'h133;
  localparam logic [9:0] GB_CH2 = 10'h2CC;

  // Video preamble: CTL0=1 on channel 1, CTL2/3=0 on channel 2.
  localparam logic [1:0] PRE_CD_CH1 = 2'b01;
  localparam logic [1:0] PRE_CD_CH2 = 2'b00;
  localparam logic [1:0] CD_IDLE    = 2'b00;

  typedef enum logic [1:0] {CM_CTRL, CM_VIDEO, CM_GUARD} chan_mode_t;

  function automatic logic [9:0] ctrl_code(input logic [1:0] cd);
    case (cd)
      2'b00:   ctrl_code = CTL_CODE_00;
      2'b01:   ctrl_code = CTL_CODE_01;
      2'b10:   ctrl_code = CTL_CODE_10;
      default: ctrl_code = CTL_CODE_11;
    endcase
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    ones8 = '0;
    for (int i = 0; i < 8; i++) ones8 = ones8 + {3'b000, v[i]};
  endfunction

endpackage

// File: rtl/tmds_chan_enc.sv
// tmds_chan_enc: one TMDS channel. DVI 8b/10b video encoder with signed
// running disparity, plus an output mux for control and guard-band symbols.
//   clk, rst_n (sync, active low), ce (hold when 0)
//   mode  : CM_VIDEO / CM_CTRL / CM_GUARD for this cycle
//   d     : 8-bit video data
//   cd    : 2-bit control data (used in CM_CTRL)
//   guard : guard-band symbol (used in CM_GUARD)
//   q     : registered 10-bit symbol, LSB first on the wire
module tmds_chan_enc
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  chan_mode_t mode,
  input  logic [7:0] d,
  input  logic [1:0] cd,
  input  logic [9:0] guard,
  output logic [9:0] q
);

  logic [3:0]        n1d, n1q;
  logic              use_xnor;
  logic [8:0]        q_m;
  logic signed [4:0] cnt;
  logic signed [5:0] cnt_x, bal, cnt_nxt;
  logic [9:0]        sym;

  always_comb begin
    n1d      = ones8(d);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    q_m      = '0;
    q_m[0]   = d[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
    q_m[8]   = ~use_xnor;
    n1q      = ones8(q_m[7:0]);
    bal      = $signed({1'b0, n1q, 1'b0}) - 6'sd8;  // n1 - n0
    cnt_x    = {cnt[4], cnt};
    if ((cnt == 5'sd0) || (bal == 6'sd0)) begin
      sym     = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_nxt = q_m[8] ? (cnt_x + bal) : (cnt_x - bal);
    end else if (cnt[4] == bal[5]) begin
      // disparity and this word lean the same way: invert
      sym     = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_nxt = cnt_x + (q_m[8] ? 6'sd2 : 6'sd0) - bal;
    end else begin
      sym     = {1'b0, q_m[8], q_m[7:0]};
      cnt_nxt = cnt_x - (q_m[8] ? 6'sd0 : 6'sd2) + bal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q   <= CTL_CODE_00;
      cnt <= '0;
    end else if (ce) begin
      case (mode)
        CM_VIDEO: begin q <= sym;           cnt <= cnt_nxt[4:0]; end
        CM_GUARD: begin q <= guard;         cnt <= '0;           end
        default:  begin q <= ctrl_code(cd); cnt <= '0;           end
      endcase
    end
  end

endmodule

// File: rtl/tmds_period_encoder.sv
// tmds_period_encoder: three-channel TMDS encoder with optional HDMI
// video preamble / leading guard band derived from a look-ahead line.
//   clk, rst_n (sync, active low), ce (pixel-repetition enable)
//   de, hs, vs, rgb[23:0] : pixel input, R[23:16] G[15:8] B[7:0]
//   tmds0/1/2             : blue/green/red symbols
//   de_out                : de aligned with the symbols
// Latency: input register + LEAD-deep delay line + encoder register.
module tmds_period_encoder
  import tmds_pkg::*;
#(
  parameter int HDMI_MODE = 1,
  parameter int LEAD      = LEAD_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        de,
  input  logic        hs,
  input  logic        vs,
  input  logic [23:0] rgb,
  output logic [9:0]  tmds0,
  output logic [9:0]  tmds1,
  output logic [9:0]  tmds2,
  output logic        de_out
);

  // Stage 0 is the input register; stage LEAD is the "current" sample.
  // Stage LEAD-j holds the sample j cycles ahead of it.
  logic [LEAD:0]        vld_pipe;
  logic [LEAD:0][1:0]   sync_pipe;
  logic [LEAD:0][23:0]  pix_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      sync_pipe <= '0;
      pix_pipe  <= '0;
      de_out    <= 1'b0;
    end else if (ce) begin
      vld_pipe[0]  <= de;
      sync_pipe[0] <= {vs, hs};
      pix_pipe[0]  <= rgb;
      for (int i = 1; i <= LEAD; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        sync_pipe[i] <= sync_pipe[i-1];
        pix_pipe[i]  <= pix_pipe[i-1];
      end
      de_out <= vld_pipe[LEAD];
    end
  end

  // Period classification. With the current sample blank, any de in the
  // look-ahead is a rising edge; the nearest one decides k. Checking the
  // two nearest slots first gives the guard band priority, so short gaps
  // just lose the leading part of the preamble.
  logic       is_vid, gb_near, pre_near, is_gb, is_pre;
  chan_mode_t mode;

  always_comb begin
    gb_near  = 1'b0;
    pre_near = 1'b0;
    for (int j = 1; j <= LEAD; j++) begin
      if (j <= 2) gb_near  = gb_near  | vld_pipe[LEAD-j];
      else        pre_near = pre_near | vld_pipe[LEAD-j];
    end
    is_vid = vld_pipe[LEAD];
    is_gb  = (HDMI_MODE != 0) && !is_vid && gb_near;
    is_pre = (HDMI_MODE != 0) && !is_vid && !gb_near && pre_near;
    mode   = is_vid ? CM_VIDEO : (is_gb ? CM_GUARD : CM_CTRL);
  end

  logic [NUM_CH-1:0][7:0] ch_d;
  logic [NUM_CH-1:0][1:0] ch_cd;
  logic [NUM_CH-1:0][9:0] ch_gb, ch_q;

  assign ch_d  = {pix_pipe[LEAD][23:16], pix_pipe[LEAD][15:8], pix_pipe[LEAD][7:0]};
  assign ch_cd = {is_pre ? PRE_CD_CH2 : CD_IDLE,
                  is_pre ? PRE_CD_CH1 : CD_IDLE,
                  sync_pipe[LEAD]};
  assign ch_gb = {GB_CH2, GB_CH1, GB_CH0};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tmds_chan_enc u_enc (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .mode  (mode),
      .d     (ch_d[c]),
      .cd    (ch_cd[c]),
      .guard (ch_gb[c]),
      .q     (ch_q[c])
    );
  end

  assign tmds0 = ch_q[0];
  assign tmds1 = ch_q[1];
  assign tmds2 = ch_q[2];

endmodule
